// File: rtl/sqrt_pkg.sv
// Shared definitions for the FP16 square-root sequencing controller:
// FP16 field widths, FSM state encoding and result codes.
package sqrt_pkg;

   localparam int FP_W   = 16;
   localparam int EXP_W  = 5;
   localparam int MANT_W = 10;
   localparam int IDX_W  = 4;

   localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;

   localparam int ITER_CNT_DEF = 12;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_NORM = 3'd1,
      ST_WAIT = 3'd2,
      ST_LOAD = 3'd3,
      ST_ITER = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   localparam logic [1:0] RES_COMPUTED = 2'd0;
   localparam logic [1:0] RES_QNAN     = 2'd1;
   localparam logic [1:0] RES_PINF     = 2'd2;
   localparam logic [1:0] RES_ZERO     = 2'd3;

   // Zero has no flag of its own; it is implied by all flags being clear.
   typedef struct packed {
      logic is_normal;
      logic is_subnormal;
      logic is_nan;
      logic is_pinf;
      logic is_ninf;
   } fp_class_t;

endpackage

// File: rtl/sqrt_ctrl_if.sv
// Handshake and datapath-control bundle between the square-root controller
// and its environment (requester, normalize stage, iteration unit, consumer).
interface sqrt_ctrl_if;
   import sqrt_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   logic [FP_W-1:0]       req_data;

   logic                  nrm_enable;
   logic                  nrm_s_valid;
   logic                  nrm_sign;
   logic [EXP_W-1:0]      nrm_exp;
   logic [MANT_W-1:0]     nrm_mant;
   logic                  nrm_is_normal;
   logic                  nrm_is_subnormal;
   logic                  nrm_is_nan;
   logic                  nrm_is_pinf;
   logic                  nrm_is_ninf;
   logic                  nrm_n_valid;

   logic                  it_load;
   logic                  it_step;
   logic [IDX_W-1:0]      it_idx;

   logic                  res_valid;
   logic                  res_ready;
   logic [1:0]            res_code;
   logic                  res_sign;

   logic                  busy;

   // Controller side: drives the datapath and result handshake.
   modport master (
      input  req_valid, req_data, nrm_n_valid, res_ready,
      output req_ready,
      output nrm_enable, nrm_s_valid, nrm_sign, nrm_exp, nrm_mant,
      output nrm_is_normal, nrm_is_subnormal, nrm_is_nan, nrm_is_pinf, nrm_is_ninf,
      output it_load, it_step, it_idx,
      output res_valid, res_code, res_sign, busy
   );

   // Environment side: requester, normalize stage model and consumer.
   modport slave (
      output req_valid, req_data, nrm_n_valid, res_ready,
      input  req_ready,
      input  nrm_enable, nrm_s_valid, nrm_sign, nrm_exp, nrm_mant,
      input  nrm_is_normal, nrm_is_subnormal, nrm_is_nan, nrm_is_pinf, nrm_is_ninf,
      input  it_load, it_step, it_idx,
      input  res_valid, res_code, res_sign, busy
   );

endinterface

// File: rtl/fp16_classify.sv
// Combinational FP16 operand classifier: produces the class flags and the
// special-case result code (with sign for signed zero) for one operand.
module fp16_classify
   import sqrt_pkg::*;
(
   input  logic [FP_W-1:0] op_i,
   output fp_class_t       class_o,
   output logic [1:0]      code_o,
   output logic            code_sign_o
);

   logic              sign;
   logic [EXP_W-1:0]  exp_f;
   logic [MANT_W-1:0] mant_f;
   logic              exp_max;
   logic              exp_zero;
   logic              mant_zero;
   logic              is_zero;

   assign sign      = op_i[FP_W-1];
   assign exp_f     = op_i[FP_W-2 -: EXP_W];
   assign mant_f    = op_i[MANT_W-1:0];
   assign exp_max   = (exp_f == EXP_MAX);
   assign exp_zero  = (exp_f == '0);
   assign mant_zero = (mant_f == '0);
   assign is_zero   = exp_zero & mant_zero;

   always_comb begin
      class_o              = '0;
      class_o.is_nan       = exp_max & ~mant_zero;
      class_o.is_pinf      = exp_max & mant_zero & ~sign;
      class_o.is_ninf      = exp_max & mant_zero & sign;
      class_o.is_subnormal = exp_zero & ~mant_zero;
      class_o.is_normal    = ~exp_max & ~exp_zero;
   end

   // Priority: NaN/-inf, +inf, zero (keeps its sign), negative finite, computed.
   always_comb begin
      code_o      = RES_COMPUTED;
      code_sign_o = 1'b0;
      if (class_o.is_nan || class_o.is_ninf) begin
         code_o = RES_QNAN;
      end else if (class_o.is_pinf) begin
         code_o = RES_PINF;
      end else if (is_zero) begin
         code_o      = RES_ZERO;
         code_sign_o = sign;
      end else if (sign) begin
         code_o = RES_QNAN;
      end
   end

endmodule

// File: rtl/sqrt_ctrl.sv
// FP16 square-root sequencing controller: accepts one operand, drives the
// normalize stage and iteration unit, and returns a coded result.
// Optional macro SQRT_CTRL_BYPASS_EN: special operands skip LOAD/ITER.
module sqrt_ctrl
   import sqrt_pkg::*;
#(
   parameter int ITER_CNT = ITER_CNT_DEF   // legal range 1..15 (4-bit index)
)
(
   input  logic        clk,
   input  logic        rst_n,
   sqrt_ctrl_if.master bus
);

`ifdef SQRT_CTRL_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITER_CNT - 1);

   state_t            state_q;
   logic [FP_W-1:0]   op_q;
   logic              req_ready_q;
   logic              busy_q;
   logic              nrm_enable_q;
   logic              nrm_s_valid_q;
   logic              it_load_q;
   logic              it_step_q;
   logic [IDX_W-1:0]  it_idx_q;
   logic [IDX_W-1:0]  it_idx_d;
   logic              res_valid_q;
   logic [1:0]        res_code_q;
   logic              res_sign_q;

   fp_class_t         op_class;
   logic [1:0]        op_code;
   logic              op_code_sign;

   fp16_classify u_classify (
      .op_i        (op_q),
      .class_o     (op_class),
      .code_o      (op_code),
      .code_sign_o (op_code_sign)
   );

   assign it_idx_d = it_idx_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         op_q          <= '0;
         req_ready_q   <= 1'b1;
         busy_q        <= 1'b0;
         nrm_enable_q  <= 1'b0;
         nrm_s_valid_q <= 1'b0;
         it_load_q     <= 1'b0;
         it_step_q     <= 1'b0;
         it_idx_q      <= '0;
         res_valid_q   <= 1'b0;
         res_code_q    <= RES_COMPUTED;
         res_sign_q    <= 1'b0;
      end else begin
         nrm_s_valid_q <= 1'b0;
         it_load_q     <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  op_q          <= bus.req_data;
                  req_ready_q   <= 1'b0;
                  busy_q        <= 1'b1;
                  nrm_enable_q  <= 1'b1;
                  nrm_s_valid_q <= 1'b1;
                  state_q       <= ST_NORM;
               end
            end
            ST_NORM: begin
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.nrm_n_valid) begin
                  if (op_code == RES_COMPUTED || !BYPASS_EN) begin
                     it_load_q <= 1'b1;
                     it_idx_q  <= '0;
                     state_q   <= ST_LOAD;
                  end else begin
                     res_valid_q <= 1'b1;
                     res_code_q  <= op_code;
                     res_sign_q  <= op_code_sign;
                     state_q     <= ST_DONE;
                  end
               end
            end
            ST_LOAD: begin
               it_step_q <= 1'b1;
               it_idx_q  <= '0;
               state_q   <= ST_ITER;
            end
            ST_ITER: begin
               // The step with the last index is the final one; leave the
               // index at zero so DONE/IDLE look the same as after reset.
               if (it_idx_q == LAST_IDX) begin
                  it_step_q   <= 1'b0;
                  it_idx_q    <= '0;
                  res_valid_q <= 1'b1;
                  res_code_q  <= op_code;
                  res_sign_q  <= op_code_sign;
                  state_q     <= ST_DONE;
               end else begin
                  it_idx_q <= it_idx_d;
               end
            end
            ST_DONE: begin
               if (bus.res_ready) begin
                  res_valid_q  <= 1'b0;
                  res_code_q   <= RES_COMPUTED;
                  res_sign_q   <= 1'b0;
                  busy_q       <= 1'b0;
                  nrm_enable_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= ST_IDLE;
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               req_ready_q  <= 1'b1;
               busy_q       <= 1'b0;
               nrm_enable_q <= 1'b0;
               it_step_q    <= 1'b0;
               res_valid_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready        = req_ready_q;
   assign bus.busy             = busy_q;
   assign bus.nrm_enable       = nrm_enable_q;
   assign bus.nrm_s_valid      = nrm_s_valid_q;
   assign bus.nrm_sign         = op_q[FP_W-1];
   assign bus.nrm_exp          = op_q[FP_W-2 -: EXP_W];
   assign bus.nrm_mant         = op_q[MANT_W-1:0];
   assign bus.nrm_is_normal    = op_class.is_normal;
   assign bus.nrm_is_subnormal = op_class.is_subnormal;
   assign bus.nrm_is_nan       = op_class.is_nan;
   assign bus.nrm_is_pinf      = op_class.is_pinf;
   assign bus.nrm_is_ninf      = op_class.is_ninf;
   assign bus.it_load          = it_load_q;
   assign bus.it_step          = it_step_q;
   assign bus.it_idx           = it_idx_q;
   assign bus.res_valid        = res_valid_q;
   assign bus.res_code         = res_code_q;
   assign bus.res_sign         = res_sign_q;

endmodule

// File: tb/tb_sqrt_ctrl.sv
// Self-checking bench for sqrt_ctrl: table of directed operands, reset abort
// sequence, and randomized operands against a rule-level reference model.
module tb_sqrt_ctrl;

   localparam int ITER = 12;
`ifdef SQRT_CTRL_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam logic [1:0] C_COMP = 2'd0;
   localparam logic [1:0] C_QNAN = 2'd1;
   localparam logic [1:0] C_PINF = 2'd2;
   localparam logic [1:0] C_ZERO = 2'd3;

   // flag order: {normal, subnormal, nan, pinf, ninf}
   localparam logic [4:0] F_NORM = 5'b10000;
   localparam logic [4:0] F_SUB  = 5'b01000;
   localparam logic [4:0] F_NAN  = 5'b00100;
   localparam logic [4:0] F_PINF = 5'b00010;
   localparam logic [4:0] F_NINF = 5'b00001;
   localparam logic [4:0] F_NONE = 5'b00000;

   typedef struct {
      logic [15:0] data;
      int          hold;
      logic [1:0]  code;
      logic        sign;
      logic [4:0]  flags;
   } vec_t;

   logic clk;
   logic rst_n;
   bit   noise_en;
   logic sv_prev;
   int   n_checks;
   int   n_errors;

   sqrt_ctrl_if bus ();

   sqrt_ctrl #(.ITER_CNT(ITER)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Normalize stage stand-in: one-cycle latency valid, plus optional noise
   // that the controller must ignore outside WAIT.
   always @(negedge clk) begin
      bus.nrm_n_valid = sv_prev | (noise_en && ($urandom_range(0, 1) == 1));
      sv_prev         = bus.nrm_s_valid & bus.nrm_enable & rst_n;
   end

   task automatic chk(input string nm, input longint act, input longint req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: actual %0h required %0h", nm, act, req);
      end
   endtask

   function automatic logic [4:0] model_flags(input logic [15:0] d);
      int e = int'(d[14:10]);
      int m = int'(d[9:0]);
      logic [4:0] f = F_NONE;
      if (e == 31 && m != 0)      f = F_NAN;
      else if (e == 31)           f = d[15] ? F_NINF : F_PINF;
      else if (e == 0 && m != 0)  f = F_SUB;
      else if (e != 0)            f = F_NORM;
      return f;
   endfunction

   function automatic logic [2:0] model_code(input logic [15:0] d);
      // returns {sign, code}
      int e = int'(d[14:10]);
      int m = int'(d[9:0]);
      bit neg = d[15];
      if (e == 31 && m != 0)  return {1'b0, C_QNAN};
      if (e == 31)            return {1'b0, neg ? C_QNAN : C_PINF};
      if ((d & 16'h7FFF) == 0) return {neg, C_ZERO};
      if (neg)                return {1'b0, C_QNAN};
      return {1'b0, C_COMP};
   endfunction

   task automatic run_op(input logic [15:0] d, input int hold, input logic [1:0] e_code,
                         input logic e_sign, input logic [4:0] e_flags);
      int sv_cnt = 0, sv_cyc = -1, ld_cnt = 0, ld_cyc = -1, steps = 0, res_cyc = -1;
      bit idx_ok = 1, excl_ok = 1, en_ok = 1, hold_ok = 1;
      bit fast = BYP && (e_code != C_COMP);
      int e_res = fast ? 3 : 4 + ITER;
      logic [4:0]  flags_seen = '0;
      logic [15:0] fields_seen = '0;
      logic [1:0]  c0;
      logic        s0;
      chk("idle_req_ready", bus.req_ready, 1);
      bus.res_ready = (hold == 0);
      bus.req_valid = 1'b1;
      bus.req_data  = d;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_data  = 16'($urandom);
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (bus.nrm_s_valid) begin
            sv_cnt++;
            sv_cyc      = cyc;
            flags_seen  = {bus.nrm_is_normal, bus.nrm_is_subnormal, bus.nrm_is_nan,
                           bus.nrm_is_pinf, bus.nrm_is_ninf};
            fields_seen = {bus.nrm_sign, bus.nrm_exp, bus.nrm_mant};
         end
         if (bus.it_load) begin ld_cnt++; ld_cyc = cyc; end
         if (bus.it_step) begin
            if (bus.it_idx != 4'(steps)) idx_ok = 0;
            steps++;
         end
         if (int'(bus.nrm_s_valid) + int'(bus.it_load) + int'(bus.it_step) > 1) excl_ok = 0;
         if (!bus.nrm_enable || !bus.busy || bus.req_ready) en_ok = 0;
         if (bus.res_valid) begin res_cyc = cyc; break; end
         @(negedge clk);
      end
      chk("s_valid_count", sv_cnt, 1);
      chk("s_valid_cycle", sv_cyc, 1);
      chk("nrm_fields", fields_seen, d);
      chk("nrm_flags", flags_seen, e_flags);
      chk("load_count", ld_cnt, fast ? 0 : 1);
      if (!fast) chk("load_cycle", ld_cyc, 3);
      chk("step_count", steps, fast ? 0 : ITER);
      chk("idx_sequence", idx_ok, 1);
      chk("strobe_exclusive", excl_ok, 1);
      chk("enable_busy", en_ok, 1);
      chk("res_cycle", res_cyc, e_res);
      chk("res_code", bus.res_code, e_code);
      chk("res_sign", bus.res_sign, e_sign);
      c0 = bus.res_code;
      s0 = bus.res_sign;
      if (hold > 0) begin
         bus.req_valid = 1'b1;
         bus.req_data  = ~d;
      end
      for (int k = 1; k <= hold; k++) begin
         @(negedge clk);
         if (!bus.res_valid || bus.res_code !== c0 || bus.res_sign !== s0 ||
             bus.req_ready || !bus.busy) hold_ok = 0;
      end
      chk("hold_stable", hold_ok, 1);
      bus.res_ready = 1'b1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("post_req_ready", bus.req_ready, 1);
      chk("post_res_valid", bus.res_valid, 0);
      chk("post_busy", bus.busy, 0);
      chk("post_nrm_enable", bus.nrm_enable, 0);
      chk("post_res_code", bus.res_code, 0);
      $display("op %04h hold %0d -> code %0d sign %0d latency %0d", d, hold, c0, s0, res_cyc);
   endtask

   vec_t vecs[10];

   initial begin
      logic [15:0] d;
      logic [2:0]  m;
      bit          found;
      n_checks = 0;
      n_errors = 0;
      noise_en = 0;
      sv_prev  = 1'b0;
      bus.req_valid   = 1'b0;
      bus.req_data    = '0;
      bus.res_ready   = 1'b0;
      bus.nrm_n_valid = 1'b0;

      vecs[0] = '{16'h4400, 0, C_COMP, 1'b0, F_NORM};
      vecs[1] = '{16'h0001, 0, C_COMP, 1'b0, F_SUB};
      vecs[2] = '{16'hBC00, 0, C_QNAN, 1'b0, F_NORM};
      vecs[3] = '{16'h8000, 0, C_ZERO, 1'b1, F_NONE};
      vecs[4] = '{16'h7C00, 0, C_PINF, 1'b0, F_PINF};
      vecs[5] = '{16'h7E00, 0, C_QNAN, 1'b0, F_NAN};
      vecs[6] = '{16'hFC00, 1, C_QNAN, 1'b0, F_NINF};
      vecs[7] = '{16'h0000, 2, C_ZERO, 1'b0, F_NONE};
      vecs[8] = '{16'h3C00, 5, C_COMP, 1'b0, F_NORM};
      vecs[9] = '{16'hFE00, 0, C_QNAN, 1'b0, F_NAN};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_nrm_enable", bus.nrm_enable, 0);
      chk("rst_strobes", {bus.nrm_s_valid, bus.it_load, bus.it_step, bus.res_valid}, 0);
      chk("rst_it_idx", bus.it_idx, 0);
      chk("rst_fields", {bus.nrm_sign, bus.nrm_exp, bus.nrm_mant}, 0);
      chk("rst_res", {bus.res_code, bus.res_sign}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i])
         run_op(vecs[i].data, vecs[i].hold, vecs[i].code, vecs[i].sign, vecs[i].flags);

      // Reset pulse in the middle of the iteration sequence.
      bus.res_ready = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_data  = 16'h4400;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      found = 0;
      for (int c = 0; c < 30; c++) begin
         if (bus.it_step && bus.it_idx == 4'd5) begin found = 1; break; end
         @(negedge clk);
      end
      chk("reach_idx5", found, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_req_ready", bus.req_ready, 1);
      chk("abort_busy", bus.busy, 0);
      chk("abort_nrm_enable", bus.nrm_enable, 0);
      chk("abort_it_step", bus.it_step, 0);
      chk("abort_it_idx", bus.it_idx, 0);
      chk("abort_res_valid", bus.res_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      found = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (bus.res_valid) found = 1;
      end
      chk("abort_no_result", found, 0);
      run_op(16'h4400, 0, C_COMP, 1'b0, F_NORM);

      // Randomized operands, biased toward the special exponents.
      noise_en = 1;
      for (int n = 0; n < 40; n++) begin
         d = 16'($urandom);
         case ($urandom_range(0, 3))
            0: d[14:10] = 5'd31;
            1: d[14:10] = 5'd0;
            2: d[9:0]   = (($urandom_range(0, 1) == 1) ? 10'd0 : d[9:0]);
            default: ;
         endcase
         m = model_code(d);
         run_op(d, $urandom_range(0, 3), m[1:0], m[2], model_flags(d));
      end
      noise_en = 0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sqrt_ctrl.md
# sqrt_ctrl

Sequencing controller for the FP16 square-root datapath. It accepts one 16-bit operand at a time over a valid/ready handshake and classifies it. It then drives the registered normalize stage (enable, s_valid, fields, class flags), steps the digit-recurrence iteration unit for a fixed number of cycles, and presents a result handshake with a special-case code. One operation is in flight at a time.

## Interface
- ITER_CNT, 12, number of root-digit iterations (1..15)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  operand offered
- req_ready  out  1  controller can accept (IDLE only)
- req_data  in  16  FP16 operand {sign, exp[4:0], mant[9:0]}
- nrm_enable  out  1  normalize-stage enable; 0 clears its registers
- nrm_s_valid  out  1  one-cycle capture strobe to normalize stage
- nrm_sign / nrm_exp / nrm_mant  out  1/5/10  registered operand fields
- nrm_is_normal, nrm_is_subnormal, nrm_is_nan, nrm_is_pinf, nrm_is_ninf  out  1 each  class flags
- nrm_n_valid  in  1  normalize stage output valid
- it_load  out  1  load normalized mantissa/exponent into iteration unit
- it_step  out  1  perform one iteration
- it_idx  out  4  current iteration index
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_code  out  2  0 COMPUTED, 1 QNAN, 2 PINF, 3 ZERO
- res_sign  out  1  sign for ZERO code, else 0
- busy  out  1  state != IDLE

## Operation
- Classification of the registered operand: exp==31 & mant!=0 → nan; exp==31 & mant==0 → pinf (sign 0) or ninf (sign 1); exp==0 & mant!=0 → subnormal; exp==0 & mant==0 → zero (no flag set); otherwise normal.
- Code selection: nan or ninf → QNAN; pinf → PINF; zero → ZERO with res_sign = operand sign; sign 1 with nonzero finite value → QNAN; otherwise COMPUTED.
- States:
  - IDLE: req_ready=1. On req_valid & req_ready, register the operand → NORM.
  - NORM: nrm_s_valid=1 for exactly this cycle → WAIT.
  - WAIT: hold until nrm_n_valid=1. If code is COMPUTED → LOAD, otherwise → DONE.
  - LOAD: it_load=1 for one cycle; clear it_idx → ITER.
  - ITER: it_step=1 each cycle, it_idx counting 0..ITER_CNT-1. After the step with it_idx==ITER_CNT-1 → DONE.
  - DONE: res_valid=1, res_code/res_sign stable. On res_ready → IDLE.
- nrm_enable=1 in every state except IDLE, so the normalize registers hold through the operation and clear in IDLE.
- Exactly one of nrm_s_valid, it_load, it_step may be high in any cycle.
- it_idx width is 4 bits; ITER_CNT>15 is illegal.

## Timing
- Reset (asynchronous, any state): state IDLE; all outputs 0 except req_ready=1; it_idx=0; operand registers 0.
- Timeline, with acceptance at edge 0:
  - NORM in cycle 1; WAIT in cycle 2, since the normalize stage has 1-cycle latency.
  - LOAD in cycle 3; ITER in cycles 4..3+ITER_CNT.
  - res_valid first high in cycle 4+ITER_CNT (16 at default).
  - Special fast path: res_valid in cycle 3.
- res_valid stays high and its payload stays stable until res_ready is sampled high. No new request is accepted meanwhile.
- Back-to-back throughput: DONE→IDLE costs one bubble cycle. req_ready never combinationally depends on res_ready.
- Reset asserted mid-ITER aborts the operation with no res_valid. The next request after release behaves as after power-up.
- nrm_n_valid outside WAIT is ignored.

## Configuration
- SQRT_CTRL_BYPASS_EN defined: non-COMPUTED codes go WAIT→DONE directly (fast path above).
- SQRT_CTRL_BYPASS_EN undefined: every operand runs LOAD and the full ITER sequence. res_code still reports the special code, with uniform latency 4+ITER_CNT.

## Structure
- Shared package sqrt_pkg:
  - FP16 field widths and EXP_MAX=31
  - state encoding localparams (IDLE, NORM, WAIT, LOAD, ITER, DONE)
  - res_code localparams (RES_COMPUTED, RES_QNAN, RES_PINF, RES_ZERO)
- Sub-module fp16_classify: combinational operand → class flags and res_code. It is reused by the output formatter.
- Controller FSM, operand register and it_idx counter live in sqrt_ctrl.

## Test plan
- 0x4400 (4.0), res_ready=1 → nrm_s_valid at cycle 1, it_load at cycle 3, 12 it_step pulses with it_idx 0..11, res_valid at cycle 16, code COMPUTED.
- 0x0001 (min subnormal) → nrm_is_subnormal=1, nrm_mant=0x001, full iteration sequence, code COMPUTED.
- 0xBC00 (−1.0) → code QNAN. With BYPASS_EN: res_valid at cycle 3, no it_load. Without: res_valid at cycle 16.
- 0x8000 (−0) → code ZERO, res_sign=1. 0x7C00 → code PINF. 0x7E00 → code QNAN with nrm_is_nan=1.
- res_ready held low 5 cycles after res_valid → res_valid/res_code stable, req_ready=0, concurrent req_valid ignored. Accept on the 6th cycle, then IDLE next cycle.
- rst_n pulsed low during ITER at it_idx=5 → immediately IDLE, nrm_enable=0, it_step=0. A subsequent 0x4400 completes normally at cycle 16.
